// File: rtl/axi4_stream_pkt_frag_ext.sv
// AXI4-Stream fragmenter: repacks packets into fragments of a per-packet locked byte size,
// tagging every output word with its fragment index and a last-fragment flag.
module axi4_stream_pkt_frag_ext #(
    parameter int unsigned TDATA_WIDTH    = 64,
    parameter int unsigned TID_WIDTH      = 1,
    parameter int unsigned TDEST_WIDTH    = 1,
    parameter int unsigned TUSER_WIDTH    = 1,
    parameter int unsigned MAX_FRAG_SIZE  = 2048,
    parameter int unsigned FRAG_IDX_WIDTH = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic [$clog2(MAX_FRAG_SIZE):0]  max_frag_size_i,

    input  logic                            pkt_i_tvalid,
    output logic                            pkt_i_tready,
    input  logic [TDATA_WIDTH-1:0]          pkt_i_tdata,
    input  logic [TDATA_WIDTH/8-1:0]        pkt_i_tkeep,
    input  logic                            pkt_i_tlast,
    input  logic [TID_WIDTH-1:0]            pkt_i_tid,
    input  logic [TDEST_WIDTH-1:0]          pkt_i_tdest,
    input  logic [TUSER_WIDTH-1:0]          pkt_i_tuser,

    output logic                            pkt_o_tvalid,
    input  logic                            pkt_o_tready,
    output logic [TDATA_WIDTH-1:0]          pkt_o_tdata,
    output logic [TDATA_WIDTH/8-1:0]        pkt_o_tkeep,
    output logic [TDATA_WIDTH/8-1:0]        pkt_o_tstrb,
    output logic                            pkt_o_tlast,
    output logic [TID_WIDTH-1:0]            pkt_o_tid,
    output logic [TDEST_WIDTH-1:0]          pkt_o_tdest,
    output logic [TUSER_WIDTH-1:0]          pkt_o_tuser,

    output logic [FRAG_IDX_WIDTH-1:0]       frag_idx_o,
    output logic                            frag_last_o,
    output logic                            err_o,
    output logic [31:0]                     frag_cnt_o
);

    localparam int unsigned W    = TDATA_WIDTH / 8;
    localparam int unsigned SW   = $clog2(MAX_FRAG_SIZE) + 1;
    localparam int unsigned BW   = $clog2(2 * W) + 1;
    localparam int unsigned CW   = (SW > BW) ? SW : BW;
    localparam int unsigned BUFW = 2 * TDATA_WIDTH;

    logic [BUFW-1:0]           buf_q;
    logic [BW-1:0]             cnt_q;
    logic [SW-1:0]             frag_left_q;
    logic [SW-1:0]             size_q;
    logic                      tail_q;
    logic                      sop_q;
    logic                      rdy_q;
    logic                      err_q;
    logic [FRAG_IDX_WIDTH-1:0] frag_idx_q;
    logic [31:0]               frag_cnt_q;
    logic [TID_WIDTH-1:0]      tid_q;
    logic [TDEST_WIDTH-1:0]    tdest_q;
    logic [TUSER_WIDTH-1:0]    tuser_q;

    logic [CW-1:0]          cnt_ext, left_ext, tx, rx_n, keep_cnt, cnt_after;
    logic [W-1:0]           rx_en, tx_en, keep_p1;
    logic [TDATA_WIDTH-1:0] rx_word, tx_word;
    logic [BUFW-1:0]        buf_shift, buf_next;
    logic [SW-1:0]          eff_size;
    logic                   tvalid, tlast, last_byte, keep_contig, rx_hs, tx_hs, take;

    always_comb begin
        cnt_ext   = CW'(cnt_q);
        left_ext  = CW'(frag_left_q);
        tx        = (cnt_ext < CW'(W)) ? cnt_ext : CW'(W);
        if (left_ext < tx) begin
            tx = left_ext;
        end
        tvalid    = (cnt_q != '0) && ((cnt_ext >= CW'(W)) || (cnt_ext >= left_ext) || tail_q);
        last_byte = tvalid && tail_q && (tx == cnt_ext);
        tlast     = tvalid && ((tx == left_ext) || last_byte);

        pkt_i_tready = rdy_q && (cnt_ext <= CW'(W)) && !tail_q;
        rx_hs        = pkt_i_tvalid && pkt_i_tready;
        tx_hs        = tvalid && pkt_o_tready;

        rx_n = '0;
        for (int i = 0; i < W; i++) begin
            rx_n = rx_n + CW'(pkt_i_tkeep[i]);
        end
        // Legal tkeep is a low-aligned run of ones; anything else still yields popcount bytes
        keep_p1     = pkt_i_tkeep + W'(1);
        keep_contig = ((pkt_i_tkeep & keep_p1) == '0);
        take        = rx_hs && ((pkt_i_tkeep != '0) || pkt_i_tlast);

        for (int i = 0; i < W; i++) begin
            rx_en[i]          = (CW'(i) < rx_n);
            tx_en[i]          = (CW'(i) < tx);
            rx_word[8*i +: 8] = rx_en[i] ? pkt_i_tdata[8*i +: 8] : 8'h00;
            tx_word[8*i +: 8] = tx_en[i] ? buf_q[8*i +: 8] : 8'h00;
        end

        keep_cnt  = tx_hs ? (cnt_ext - tx) : cnt_ext;
        buf_shift = tx_hs ? (buf_q >> {tx, 3'b000}) : buf_q;
        buf_next  = buf_shift;
        cnt_after = keep_cnt;
        if (take) begin
            buf_next  = buf_shift | (BUFW'(rx_word) << {keep_cnt, 3'b000});
            cnt_after = keep_cnt + rx_n;
        end

        eff_size = max_frag_size_i;
        if ((max_frag_size_i == '0) || (max_frag_size_i > SW'(MAX_FRAG_SIZE))) begin
            eff_size = SW'(MAX_FRAG_SIZE);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            buf_q       <= '0;
            cnt_q       <= '0;
            frag_left_q <= '0;
            size_q      <= '0;
            tail_q      <= 1'b0;
            sop_q       <= 1'b1;
            rdy_q       <= 1'b0;
            err_q       <= 1'b0;
            frag_idx_q  <= '0;
            frag_cnt_q  <= '0;
            tid_q       <= '0;
            tdest_q     <= '0;
            tuser_q     <= '0;
        end else begin
            rdy_q <= 1'b1;
            err_q <= rx_hs && (!keep_contig || (pkt_i_tkeep == '0));
            buf_q <= buf_next;
            cnt_q <= BW'(cnt_after);

            if (tx_hs) begin
                if (tlast) begin
                    frag_left_q <= size_q;
                    frag_idx_q  <= frag_idx_q + FRAG_IDX_WIDTH'(1);
                    frag_cnt_q  <= frag_cnt_q + 32'd1;
                end else begin
                    frag_left_q <= frag_left_q - SW'(tx);
                end
                if (last_byte) begin
                    frag_idx_q <= '0;
                    tail_q     <= 1'b0;
                    sop_q      <= 1'b1;
                end
            end

            // SOP can only coincide with an empty buffer, so it never races a tx update
            if (take) begin
                if (sop_q) begin
                    tid_q       <= pkt_i_tid;
                    tdest_q     <= pkt_i_tdest;
                    tuser_q     <= pkt_i_tuser;
                    size_q      <= eff_size;
                    frag_left_q <= eff_size;
                    frag_idx_q  <= '0;
                    sop_q       <= 1'b0;
                end
                if (pkt_i_tlast) begin
                    if (cnt_after == '0) begin
                        // Zero-byte tail with nothing buffered: the packet is already out
                        sop_q      <= 1'b1;
                        frag_idx_q <= '0;
                    end else begin
                        tail_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign pkt_o_tvalid = tvalid;
    assign pkt_o_tdata  = tx_word;
    assign pkt_o_tkeep  = tx_en;
    assign pkt_o_tstrb  = tx_en;
    assign pkt_o_tlast  = tlast;
    assign pkt_o_tid    = tid_q;
    assign pkt_o_tdest  = tdest_q;
    assign pkt_o_tuser  = tuser_q;
    assign frag_idx_o   = frag_idx_q;
    assign frag_last_o  = last_byte;
    assign err_o        = err_q;
    assign frag_cnt_o   = frag_cnt_q;

endmodule

// File: tb/tb_axi4_stream_pkt_frag_ext.sv
// Randomized and directed bench for axi4_stream_pkt_frag_ext, checked against a
// packet-level fragmentation model.
module tb_axi4_stream_pkt_frag_ext;

    localparam int W    = 8;
    localparam int MAXF = 2048;
    localparam int SW   = 12;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic [SW-1:0] max_frag_size_i;
    logic          pkt_i_tvalid, pkt_i_tready, pkt_i_tlast;
    logic [63:0]   pkt_i_tdata;
    logic [7:0]    pkt_i_tkeep;
    logic          pkt_i_tid, pkt_i_tdest, pkt_i_tuser;
    logic          pkt_o_tvalid, pkt_o_tready, pkt_o_tlast;
    logic [63:0]   pkt_o_tdata;
    logic [7:0]    pkt_o_tkeep, pkt_o_tstrb;
    logic          pkt_o_tid, pkt_o_tdest, pkt_o_tuser;
    logic [7:0]    frag_idx_o;
    logic          frag_last_o, err_o;
    logic [31:0]   frag_cnt_o;

    always #5 clk_i = ~clk_i;

    axi4_stream_pkt_frag_ext dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .max_frag_size_i(max_frag_size_i),
        .pkt_i_tvalid(pkt_i_tvalid), .pkt_i_tready(pkt_i_tready), .pkt_i_tdata(pkt_i_tdata),
        .pkt_i_tkeep(pkt_i_tkeep), .pkt_i_tlast(pkt_i_tlast), .pkt_i_tid(pkt_i_tid),
        .pkt_i_tdest(pkt_i_tdest), .pkt_i_tuser(pkt_i_tuser),
        .pkt_o_tvalid(pkt_o_tvalid), .pkt_o_tready(pkt_o_tready), .pkt_o_tdata(pkt_o_tdata),
        .pkt_o_tkeep(pkt_o_tkeep), .pkt_o_tstrb(pkt_o_tstrb), .pkt_o_tlast(pkt_o_tlast),
        .pkt_o_tid(pkt_o_tid), .pkt_o_tdest(pkt_o_tdest), .pkt_o_tuser(pkt_o_tuser),
        .frag_idx_o(frag_idx_o), .frag_last_o(frag_last_o), .err_o(err_o),
        .frag_cnt_o(frag_cnt_o)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [7:0]  idx;
        logic        flast;
        logic [2:0]  side;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] wd_q[$];
    logic [7:0]  wk_q[$];
    logic        wl_q[$];
    int          total = 0;
    int          bad = 0;
    int          exp_frags = 0;
    int          out_mode = 0;
    bit          mon_en = 1'b0;
    logic        hold_pend;
    logic [63:0] held_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: gather the packet's bytes, cut into fragments, then into W-byte words
    task automatic model_pkt(input int size, input logic [2:0] side);
        byte unsigned b[$];
        logic [63:0]  d;
        exp_t         e;
        int           n, eff, off, idx, flen, nb;
        for (int i = 0; i < wd_q.size(); i++) begin
            d = wd_q[i];
            n = $countones(wk_q[i]);
            for (int j = 0; j < n; j++) b.push_back(d[8*j +: 8]);
        end
        eff = (size == 0 || size > MAXF) ? MAXF : size;
        off = 0;
        idx = 0;
        while (off < b.size()) begin
            flen = (b.size() - off < eff) ? b.size() - off : eff;
            for (int w = 0; w < flen; w += W) begin
                nb = (flen - w < W) ? flen - w : W;
                e = '0;
                for (int k = 0; k < nb; k++) e.data[8*k +: 8] = b[off + w + k];
                e.keep  = 8'((1 << nb) - 1);
                e.last  = (w + nb == flen);
                e.idx   = 8'(idx);
                e.flast = e.last && (off + flen == b.size());
                e.side  = side;
                exp_q.push_back(e);
            end
            off += flen;
            idx++;
            exp_frags++;
        end
    endtask

    task automatic send_word(input logic [63:0] d, input logic [7:0] k, input logic l,
                             input logic [2:0] side);
        int   cyc;
        logic exp_err;
        exp_err      = (k == 8'd0) || ((k & (k + 8'd1)) != 8'd0);
        pkt_i_tdata  = d;
        pkt_i_tkeep  = k;
        pkt_i_tlast  = l;
        pkt_i_tid    = side[2];
        pkt_i_tdest  = side[1];
        pkt_i_tuser  = side[0];
        pkt_i_tvalid = 1'b1;
        cyc = 0;
        @(negedge clk_i);
        while (!pkt_i_tready && cyc < 5000) begin
            cyc++;
            @(negedge clk_i);
        end
        check("in_accept", 64'(cyc < 5000), 64'd1);
        @(posedge clk_i); #1;
        pkt_i_tvalid = 1'b0;
        @(negedge clk_i);
        check("err_o", 64'(err_o), 64'(exp_err));
        @(posedge clk_i); #1;
    endtask

    task automatic send_pkt(input int nbytes, input int size, input int after_size,
                            input bit full, input int special);
        logic [2:0] side;
        int         left, kb;
        wd_q.delete();
        wk_q.delete();
        wl_q.delete();
        side = 3'($urandom);
        left = nbytes;
        while (left > 0) begin
            kb = full ? W : $urandom_range(1, W);
            if (kb > left) kb = left;
            left -= kb;
            wd_q.push_back({$urandom, $urandom});
            wk_q.push_back(8'((1 << kb) - 1));
            wl_q.push_back(left == 0);
            if (special != 0 && wd_q.size() == 1 && left > 0) begin
                wd_q.push_back({$urandom, $urandom});
                wk_q.push_back(special == 1 ? 8'b0000_0101 : 8'h00);
                wl_q.push_back(1'b0);
            end
        end
        max_frag_size_i = SW'(size);
        model_pkt(size, side);
        for (int i = 0; i < wd_q.size(); i++) begin
            if (!full) repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
            send_word(wd_q[i], wk_q[i], wl_q[i], (i == 0) ? side : 3'($urandom));
            if (i == 0) max_frag_size_i = SW'(after_size);
        end
    endtask

    task automatic drain();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 20000) begin
            @(posedge clk_i);
            cyc++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    initial begin
        pkt_o_tready = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            case (out_mode)
                0:       pkt_o_tready = 1'b1;
                1:       pkt_o_tready = 1'($urandom_range(0, 1));
                default: pkt_o_tready = 1'b0;
            endcase
        end
    end

    always @(negedge clk_i) begin
        if (!rst_n_i || !mon_en) begin
            hold_pend <= 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_tvalid", 64'(pkt_o_tvalid), 64'd1);
                check("hold_tdata", pkt_o_tdata, held_data);
            end
            if (pkt_o_tvalid && pkt_o_tready) begin
                check("exp_avail", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    check("tdata", pkt_o_tdata, exp_q[0].data);
                    check("tkeep", 64'(pkt_o_tkeep), 64'(exp_q[0].keep));
                    check("tstrb", 64'(pkt_o_tstrb), 64'(exp_q[0].keep));
                    check("tlast", 64'(pkt_o_tlast), 64'(exp_q[0].last));
                    check("frag_idx", 64'(frag_idx_o), 64'(exp_q[0].idx));
                    check("frag_last", 64'(frag_last_o), 64'(exp_q[0].flast));
                    check("sideband", 64'({pkt_o_tid, pkt_o_tdest, pkt_o_tuser}),
                          64'(exp_q[0].side));
                    void'(exp_q.pop_front());
                end
            end
            hold_pend <= pkt_o_tvalid && !pkt_o_tready;
            held_data <= pkt_o_tdata;
        end
    end

    initial begin
        rst_n_i         = 1'b0;
        pkt_i_tvalid    = 1'b0;
        pkt_i_tdata     = '0;
        pkt_i_tkeep     = '0;
        pkt_i_tlast     = 1'b0;
        pkt_i_tid       = 1'b0;
        pkt_i_tdest     = 1'b0;
        pkt_i_tuser     = 1'b0;
        max_frag_size_i = SW'(16);
        #12;
        check("rst_tvalid", 64'(pkt_o_tvalid), 64'd0);
        check("rst_tready", 64'(pkt_i_tready), 64'd0);
        check("rst_frag_idx", 64'(frag_idx_o), 64'd0);
        check("rst_frag_last", 64'(frag_last_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_frag_cnt", 64'(frag_cnt_o), 64'd0);
        #10 rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        check("tready_after_rst", 64'(pkt_i_tready), 64'd1);
        mon_en = 1'b1;

        send_pkt(13, 16, 16, 1'b1, 0);
        drain();
        check("frag_cnt_13B", 64'(frag_cnt_o), 64'd1);
        send_pkt(40, 20, 20, 1'b1, 0);
        drain();
        check("frag_cnt_40B", 64'(frag_cnt_o), 64'(exp_frags));
        send_pkt(40, 20, 12, 1'b1, 0);
        send_pkt(30, 12, 12, 1'b1, 0);
        drain();
        send_pkt(50, 0, 0, 1'b1, 0);
        send_pkt(40, 3000, 20, 1'b1, 0);
        drain();
        send_pkt(20, 16, 16, 1'b1, 1);
        send_pkt(20, 16, 16, 1'b1, 2);
        drain();
        send_pkt(260, 1, 1, 1'b1, 0);
        drain();
        check("frag_cnt_directed", 64'(frag_cnt_o), 64'(exp_frags));

        out_mode = 1;
        repeat (200) send_pkt($urandom_range(1, 300), $urandom_range(8, MAXF),
                              $urandom_range(0, 4095), 1'b0, 0);
        drain();
        check("frag_cnt_random", 64'(frag_cnt_o), 64'(exp_frags));
        check("idle_tvalid", 64'(pkt_o_tvalid), 64'd0);

        out_mode = 2;
        repeat (2) begin @(posedge clk_i); #1; end
        mon_en = 1'b0;
        send_word({$urandom, $urandom}, 8'hFF, 1'b0, 3'b000);
        send_word({$urandom, $urandom}, 8'hFF, 1'b0, 3'b000);
        @(negedge clk_i);
        check("pre_rst_tvalid", 64'(pkt_o_tvalid), 64'd1);
        #1 rst_n_i = 1'b0;
        #1;
        check("midrst_tvalid", 64'(pkt_o_tvalid), 64'd0);
        check("midrst_tready", 64'(pkt_i_tready), 64'd0);
        check("midrst_frag_cnt", 64'(frag_cnt_o), 64'd0);
        exp_q.delete();
        exp_frags = 0;
        @(posedge clk_i);
        #3 rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        out_mode = 0;
        repeat (2) begin @(posedge clk_i); #1; end
        mon_en = 1'b1;
        send_pkt(30, 20, 20, 1'b1, 0);
        drain();
        check("frag_cnt_after_rst", 64'(frag_cnt_o), 64'(exp_frags));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
